// File: rtl/bt656_line_extractor_if.sv
// Byte-stream in / line-FIFO write port and status bundle for the BT.656 line extractor.
// master = extractor side, slave = stream source / FIFO / status observer.
interface bt656_line_extractor_if #(
  parameter int unsigned LINE_NUM_WIDTH = 10
);
  logic [7:0]                data_in;
  logic                      full;
  logic [7:0]                data_out;
  logic                      write;
  logic                      field;
  logic                      vblank;
  logic [LINE_NUM_WIDTH-1:0] line_num;
  logic                      line_start;
  logic                      sync_err;
  logic                      short_line;
  logic                      overflow;

  modport master (
    input  data_in, full,
    output data_out, write, field, vblank, line_num,
           line_start, sync_err, short_line, overflow
  );

  modport slave (
    output data_in, full,
    input  data_out, write, field, vblank, line_num,
           line_start, sync_err, short_line, overflow
  );
endinterface

// File: rtl/bt656_line_extractor.sv
// Parses a BT.656 byte stream, validates XY headers and forwards one line of
// active-video bytes per active SAV to the line FIFO write port.
module bt656_line_extractor #(
  parameter int unsigned LINE_BYTES     = 1440,
  parameter int unsigned LINE_NUM_WIDTH = 10
) (
  input logic                    clock,
  input logic                    reset,
  bt656_line_extractor_if.master bus
);

  localparam int unsigned CNT_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    SEARCH,
    HDR1,
    HDR2,
    HDR3,
    ACTIVE
  } state_e;

  state_e                    state_q, state_d;
  logic [LINE_NUM_WIDTH-1:0] next_line_q, next_line_d;
  logic [LINE_NUM_WIDTH-1:0] line_num_q, line_num_d;
  logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]                data_out_q, data_out_d;
  logic                      write_q, write_d;
  logic                      field_q, field_d;
  logic                      vblank_q, vblank_d;
  logic                      line_start_q, line_start_d;
  logic                      sync_err_q, sync_err_d;
  logic                      short_line_q, short_line_d;
  logic                      overflow_q, overflow_d;

  logic is_ff_c, is_00_c;
  logic xy_f_c, xy_v_c, xy_h_c, xy_ok_c;

  // XY = {1, F, V, H, P3, P2, P1, P0}; protection bits must match F/V/H
  always_comb begin
    is_ff_c = (bus.data_in == 8'hFF);
    is_00_c = (bus.data_in == 8'h00);
    xy_f_c  = bus.data_in[6];
    xy_v_c  = bus.data_in[5];
    xy_h_c  = bus.data_in[4];
    xy_ok_c = bus.data_in[7]
            & (bus.data_in[3] == (xy_v_c ^ xy_h_c))
            & (bus.data_in[2] == (xy_f_c ^ xy_h_c))
            & (bus.data_in[1] == (xy_f_c ^ xy_v_c))
            & (bus.data_in[0] == (xy_f_c ^ xy_v_c ^ xy_h_c));
  end

  always_comb begin
    state_d      = state_q;
    next_line_d  = next_line_q;
    line_num_d   = line_num_q;
    byte_cnt_d   = byte_cnt_q;
    data_out_d   = data_out_q;
    field_d      = field_q;
    vblank_d     = vblank_q;
    overflow_d   = overflow_q;
    write_d      = 1'b0;
    line_start_d = 1'b0;
    sync_err_d   = 1'b0;
    short_line_d = 1'b0;

    case (state_q)
      SEARCH: begin
        if (is_ff_c) state_d = HDR1;
      end
      HDR1: begin
        if (is_00_c)      state_d = HDR2;
        else if (is_ff_c) state_d = HDR1;
        else              state_d = SEARCH;
      end
      HDR2: begin
        if (is_00_c)      state_d = HDR3;
        else if (is_ff_c) state_d = HDR1;
        else              state_d = SEARCH;
      end
      HDR3: begin
        state_d = SEARCH;
        if (!xy_ok_c) begin
          sync_err_d = 1'b1;
        end else begin
          field_d  = xy_f_c;
          vblank_d = xy_v_c;
          if (xy_v_c) next_line_d = '0;
          if (!xy_h_c && !xy_v_c) begin
            line_num_d  = next_line_q;
            next_line_d = next_line_q + LINE_NUM_WIDTH'(1);
            byte_cnt_d  = '0;
            state_d     = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        // An FF inside the line means a new header arrived before the line finished
        if (is_ff_c) begin
          short_line_d = 1'b1;
          state_d      = HDR1;
        end else begin
          data_out_d   = bus.data_in;
          line_start_d = (byte_cnt_q == '0);
          if (bus.full) overflow_d = 1'b1;
          else          write_d    = 1'b1;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q == LAST_BYTE) state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SEARCH;
      next_line_q  <= '0;
      line_num_q   <= '0;
      byte_cnt_q   <= '0;
      data_out_q   <= '0;
      write_q      <= 1'b0;
      field_q      <= 1'b0;
      vblank_q     <= 1'b1;
      line_start_q <= 1'b0;
      sync_err_q   <= 1'b0;
      short_line_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_line_q  <= next_line_d;
      line_num_q   <= line_num_d;
      byte_cnt_q   <= byte_cnt_d;
      data_out_q   <= data_out_d;
      write_q      <= write_d;
      field_q      <= field_d;
      vblank_q     <= vblank_d;
      line_start_q <= line_start_d;
      sync_err_q   <= sync_err_d;
      short_line_q <= short_line_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.write      = write_q;
  assign bus.field      = field_q;
  assign bus.vblank     = vblank_q;
  assign bus.line_num   = line_num_q;
  assign bus.line_start = line_start_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.short_line = short_line_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_bt656_line_extractor.sv
// Bench for bt656_line_extractor: stimulus is built from line/header descriptors,
// each byte carrying the outputs it must produce one edge later.
module tb_bt656_line_extractor;

  localparam int unsigned LB  = 1440;
  localparam int unsigned LNW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bt656_line_extractor_if #(.LINE_NUM_WIDTH(LNW)) bus ();

  bt656_line_extractor #(.LINE_BYTES(LB), .LINE_NUM_WIDTH(LNW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]     d;
    logic           full;
    logic           rst;
    logic           wr;
    logic           ls;
    logic           se;
    logic           sl;
    logic           fld;
    logic           vb;
    logic           ovf;
    logic [7:0]     dout;
    logic [LNW-1:0] ln;
  } vec_t;

  vec_t q[$];
  int   mark_idx[$];
  int   mark_wr[$];

  // Visible state of the reference: what the outputs hold after each byte
  logic m_fld, m_vb, m_ovf;
  int   m_ln, m_next;

  int n_vec = 0;
  int n_err = 0;
  int cur_i = 0;

  function automatic logic [7:0] xy(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at vector %0d: got %0h, expected %0h", name, cur_i, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fld  = 1'b0;
    m_vb   = 1'b1;
    m_ovf  = 1'b0;
    m_ln   = 0;
    m_next = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic full, input logic r,
                      input logic wr, input logic ls, input logic se, input logic sl);
    vec_t v;
    v.d = d; v.full = full; v.rst = r;
    v.wr = wr; v.ls = ls; v.se = se; v.sl = sl;
    v.fld = m_fld; v.vb = m_vb; v.ovf = m_ovf;
    v.dout = r ? 8'h00 : d;
    v.ln = LNW'(m_ln);
    q.push_back(v);
  endtask

  function automatic logic [7:0] rbyte();
    return 8'($urandom_range(0, 254));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic put_reset();
    model_reset();
    push(rbyte(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Non-FF bytes while the parser is hunting: nothing may be written
  task automatic filler(input int n);
    for (int k = 0; k < n; k++) push(rbyte(), rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic header(input logic f, input logic v, input logic h, input bit bad,
                        input bit aborts_line, input int extra_ff, output bit active);
    logic [7:0] b;
    int         bitsel;
    for (int k = 0; k <= extra_ff; k++)
      push(8'hFF, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'(aborts_line && k == 0));
    push(8'h00, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'h00, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    b = xy(f, v, h);
    active = 1'b0;
    if (bad) begin
      bitsel = $urandom_range(0, 4);
      b = b ^ (8'h01 << ((bitsel == 4) ? 7 : bitsel));
      push(b, rbit(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      m_fld = f;
      m_vb  = v;
      if (v) m_next = 0;
      if (!h && !v) begin
        m_ln   = m_next;
        m_next = (m_next + 1) % (1 << LNW);
        active = 1'b1;
      end
      push(b, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // n active bytes; full held over [flo,fhi]; reset asserted on byte rst_at (if >= 0)
  task automatic line(input int n, input int flo, input int fhi, input int rst_at);
    logic [7:0] b;
    logic       fl;
    for (int k = 0; k < n; k++) begin
      if (k == rst_at) begin
        put_reset();
      end else if (rst_at >= 0 && k > rst_at) begin
        push(rbyte(), rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        b  = rbyte();
        fl = (k >= flo && k <= fhi);
        if (fl) m_ovf = 1'b1;
        push(b, fl, 1'b0, !fl, k == 0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic mark(input int writes);
    mark_idx.push_back(q.size());
    mark_wr.push_back(writes);
  endtask

  task automatic build();
    bit act;
    bit pend;
    int n, flo, fhi;
    model_reset();
    put_reset();
    filler(5);
    mark(0);

    // clean line, with counting bytes 0x10..0x8F
    header(0, 0, 0, 0, 0, 0, act);
    for (int k = 0; k < int'(LB); k++)
      push(8'(8'h10 + (k % 128)), 1'b0, 1'b0, 1'b1, 1'(k == 0), 1'b0, 1'b0);
    header(0, 0, 1, 0, 0, 0, act);
    mark(LB);

    // three lines, vertical-blank header, then line 0 again
    for (int l = 0; l < 3; l++) begin
      header(0, 0, 0, 0, 0, 0, act);
      line(LB, -1, -2, -1);
      header(0, 0, 1, 0, 0, 1, act);
    end
    header(0, 1, 0, 0, 0, 0, act);
    filler(4);
    header(0, 0, 0, 0, 0, 0, act);
    line(LB, -1, -2, -1);
    header(0, 0, 1, 0, 0, 0, act);
    mark(4 * LB);

    // bad protection bits followed by a line's worth of bytes
    header(0, 0, 0, 1, 0, 0, act);
    filler(LB);
    mark(0);

    // short line aborted by an EAV
    header(0, 0, 0, 0, 0, 0, act);
    line(500, -1, -2, -1);
    header(0, 0, 1, 0, 1, 0, act);
    mark(500);

    // backpressure over bytes 100..109, then a normal line
    header(0, 0, 0, 0, 0, 0, act);
    line(LB, 100, 109, -1);
    header(0, 0, 1, 0, 0, 0, act);
    header(0, 0, 0, 0, 0, 0, act);
    line(LB, -1, -2, -1);
    header(0, 0, 1, 0, 0, 0, act);
    mark(LB - 10 + LB);

    // reset on byte 700, then a fresh line
    header(0, 0, 0, 0, 0, 0, act);
    line(LB, -1, -2, 700);
    filler(3);
    header(0, 0, 0, 0, 0, 0, act);
    line(LB, -1, -2, -1);
    header(0, 0, 1, 0, 0, 0, act);
    mark(700 + LB);

    // FF on the final byte slot aborts the line
    header(1, 0, 0, 0, 0, 0, act);
    line(LB - 1, -1, -2, -1);
    header(1, 0, 1, 0, 1, 0, act);
    mark(LB - 1);

    // randomized headers and lines
    pend = 1'b0;
    for (int r = 0; r < 16; r++) begin
      if (pend) begin
        n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LB - 1)) : int'(LB);
        flo = -1; fhi = -2;
        if ($urandom_range(0, 2) == 0) begin
          flo = $urandom_range(0, LB - 1);
          fhi = flo + int'($urandom_range(0, 20));
        end
        line(n, flo, fhi, -1);
        if (n < int'(LB)) begin
          header(rbit(), 1'($urandom_range(0, 3) == 0), rbit(), $urandom_range(0, 7) == 0,
                 1, $urandom_range(0, 2), act);
          pend = act;
        end else begin
          pend = 1'b0;
        end
      end else begin
        filler($urandom_range(0, 20));
        header(rbit(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
               $urandom_range(0, 7) == 0, 0, $urandom_range(0, 2), act);
        pend = act;
      end
    end
    if (pend) line(LB, -1, -2, -1);
    filler(4);
  endtask

  initial begin
    int wr_cnt, prev_wr, mk;
    vec_t e;
    rst         = 1'b1;
    bus.data_in = 8'h00;
    bus.full    = 1'b0;

    // pin the header encoder against hand-known codes
    n_vec++; chk("xy_sav", 32'(xy(0, 0, 0)), 32'h80);
    n_vec++; chk("xy_eav", 32'(xy(0, 0, 1)), 32'h9D);
    n_vec++; chk("xy_vsav", 32'(xy(0, 1, 0)), 32'hAB);
    n_vec++; chk("xy_f1eav", 32'(xy(1, 1, 1)), 32'hF1);

    build();
    wr_cnt  = 0;
    prev_wr = 0;
    mk      = 0;

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst         = q[i].rst;
      bus.data_in = q[i].d;
      bus.full    = q[i].full;
      @(posedge clk);
      #1;
      cur_i = i;
      e = q[i];
      n_vec++;
      chk("write",      32'(bus.write),      32'(e.wr));
      chk("line_start", 32'(bus.line_start), 32'(e.ls));
      chk("sync_err",   32'(bus.sync_err),   32'(e.se));
      chk("short_line", 32'(bus.short_line), 32'(e.sl));
      chk("field",      32'(bus.field),      32'(e.fld));
      chk("vblank",     32'(bus.vblank),     32'(e.vb));
      chk("overflow",   32'(bus.overflow),   32'(e.ovf));
      chk("line_num",   32'(bus.line_num),   32'(e.ln));
      if (e.wr || e.rst) chk("data_out", 32'(bus.data_out), 32'(e.dout));
      if (bus.write === 1'b1) wr_cnt++;
      if (mk < mark_idx.size() && i + 1 == mark_idx[mk]) begin
        n_vec++;
        chk("section_writes", 32'(wr_cnt - prev_wr), 32'(mark_wr[mk]));
        prev_wr = wr_cnt;
        mk++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
